mole_hit_scorer: RTL and testbench
==================================

Name: mole_hit_scorer

Overview:
- Consumer side of the mole control bus: reads the 8-bit `ctrl` pattern from the random mole generator and the player's 8 hit keys.
- Detects hits, misses and escaped moles, and maintains score, miss count and lives.
- Runs the game state machine: IDLE, PLAY, OVER.
- Sits between the generator and the display/HEX driver logic.

Parameters:
- SCORE_W, 10, width of the score counter; saturates at 2^SCORE_W-1.
- MISS_W, 8, width of the miss counter; saturates at all-ones.
- LIVES_INIT, 5, lives loaded on game start; range 1..7.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high.
- start  input  1  level or pulse; acted on only in IDLE or OVER.
- ctrl  input  8  mole-up lines from the generator; synchronous to CLOCK_50; bit i high = mole i visible.
- key  input  8  raw player keys; active-high; asynchronous to CLOCK_50.
- score  output  SCORE_W  hit total.
- miss_cnt  output  MISS_W  wrong-hole key presses.
- lives  output  3  remaining lives.
- visible  output  8  ctrl & ~whacked; moles still to be drawn.
- hit_pulse  output  1  one-cycle pulse, at least one hit this cycle.
- miss_pulse  output  1  one-cycle pulse, at least one miss this cycle.
- escape_pulse  output  1  one-cycle pulse, at least one mole escaped this cycle.
- playing  output  1  high in PLAY.
- game_over  output  1  high in OVER.

Behaviour:
- Reset (asynchronous, active-high, clock CLOCK_50):
  - state = IDLE; score = 0; miss_cnt = 0; lives = LIVES_INIT.
  - whacked = 0; all pulses = 0; synchronizer and ctrl_q flops = 0.
  - visible is combinational, so it reads ctrl during reset.
  - Reset mid-game aborts immediately, with no pulse.
- Key path:
  - 2-flop synchronizer k1 -> k2, then history flop k3.
  - kedge = k2 & ~k3, so each press counts once regardless of hold time.
  - A key high before clock edge 1 gives kedge during the cycle after edge 2; results are registered at edge 3.
  - Total latency: 3 clocks from key to score/pulse.
- ctrl path: ctrl_q registers ctrl every cycle; fall = ctrl_q & ~ctrl.
- Per-bit classification, evaluated only in PLAY, each cycle:
  - hit[i] = kedge[i] & ctrl[i] & ~whacked[i].
  - miss[i] = kedge[i] & ~ctrl[i].
  - kedge[i] & ctrl[i] & whacked[i] is ignored (repeat whack on the same appearance).
  - escape[i] = fall[i] & ~whacked[i].
- whacked[i] update:
  - Set on hit[i].
  - Cleared whenever ctrl[i] = 0.
  - Clear has priority; the next appearance starts un-whacked.
- Same-cycle key edge and fall on one bit: ctrl[i] = 0, so it counts as a miss and, if not whacked, an escape. Both are counted.
- Counter arithmetic:
  - score += popcount(hit), 0..8, saturating at max.
  - miss_cnt += popcount(miss), saturating.
  - lives -= popcount(escape), floored at 0.
  - Multiple bits in one cycle are all counted.
- Pulses: registered, high for exactly the one cycle following the evaluating edge.
- State machine:
  - IDLE:
    - Outputs held; classification disabled.
    - start = 1 -> PLAY, and at the same edge: score = 0, miss_cnt = 0, lives = LIVES_INIT, whacked = 0.
  - PLAY:
    - Classification enabled; start ignored.
    - If the computed next lives = 0 -> OVER at the same edge as the decrement.
  - OVER:
    - Counters frozen; game_over = 1; key and ctrl ignored; no pulses.
    - start = 1 -> PLAY, with the same init as IDLE -> PLAY.
  - A start held high across the OVER -> PLAY edge has no further effect.
- Score and miss counters stop at max with no wrap; lives never underflow.

Test Plan:
- Reset mid-PLAY with score = 37 -> next cycle: score = 0, lives = 5, state IDLE, all pulses 0.
- start pulse; ctrl = 8'h04 held; key[2] rises and is held 20 cycles -> exactly one hit_pulse 3 clocks after the rise; score = 1; visible = 8'h00; second press on the same appearance -> no change.
- ctrl = 8'h04; key[5] press -> miss_pulse; miss_cnt = 1; score unchanged.
- ctrl 8'h81 -> 8'h00 with neither mole whacked -> one escape_pulse; lives 5 -> 3.
- key[0] and key[1] rise in the same cycle with ctrl = 8'h03 -> score += 2; single hit_pulse.
- lives = 1, mole escapes -> lives = 0 and game_over = 1 on the same edge; further keys ignored; start -> lives = 5, score = 0, playing = 1.
- Force score = 1023 then hit -> score stays 1023.

Source files
------------

// File: rtl/mole_hit_scorer_if.sv
// rtl/mole_hit_scorer_if.sv - mole control bus between generator and scorer
// The generator drives the mole-up pattern; the scorer returns the moles still to draw.
interface mole_hit_scorer_if;
   logic [7:0] ctrl;
   logic [7:0] visible;

   modport master (output ctrl, input visible);
   modport slave (input ctrl, output visible);
endinterface

// File: rtl/mole_hit_scorer.sv
// rtl/mole_hit_scorer.sv - whack-a-mole hit/miss/escape scorer and game state machine
// Keys are synchronised and edge-detected; classification runs only while playing.
module mole_hit_scorer #(
   parameter int SCORE_W    = 10,
   parameter int MISS_W     = 8,
   parameter int LIVES_INIT = 5
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         key,
   mole_hit_scorer_if.slave   bus,
   output logic [SCORE_W-1:0] score,
   output logic [MISS_W-1:0]  miss_cnt,
   output logic [2:0]         lives,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               escape_pulse,
   output logic               playing,
   output logic               game_over
);

   localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
   state_t state;

   logic [7:0] k1, k2, k3;
   logic [7:0] ctrl_q;
   logic [7:0] whacked;

   logic [7:0] kedge, fall, hit, miss, escape;
   logic [3:0] n_hit, n_miss, n_esc;
   logic [SCORE_W:0] score_sum;
   logic [MISS_W:0]  miss_sum;
   logic [SCORE_W-1:0] score_next;
   logic [MISS_W-1:0]  miss_next;
   logic [2:0] lives_next;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

   assign kedge  = k2 & ~k3;
   assign fall   = ctrl_q & ~bus.ctrl;
   assign hit    = kedge & bus.ctrl & ~whacked;
   assign miss   = kedge & ~bus.ctrl;
   assign escape = fall & ~whacked;

   assign n_hit  = popcount8(hit);
   assign n_miss = popcount8(miss);
   assign n_esc  = popcount8(escape);

   // Carry out of the extended sum marks saturation.
   assign score_sum  = {1'b0, score} + {{(SCORE_W-3){1'b0}}, n_hit};
   assign miss_sum   = {1'b0, miss_cnt} + {{(MISS_W-3){1'b0}}, n_miss};
   assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   assign miss_next  = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
   assign lives_next = (n_esc >= {1'b0, lives}) ? 3'd0 : lives - n_esc[2:0];

   assign bus.visible = bus.ctrl & ~whacked;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         k1           <= '0;
         k2           <= '0;
         k3           <= '0;
         ctrl_q       <= '0;
         whacked      <= '0;
         score        <= '0;
         miss_cnt     <= '0;
         lives        <= LIVES_RST;
         hit_pulse    <= 1'b0;
         miss_pulse   <= 1'b0;
         escape_pulse <= 1'b0;
         playing      <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         k1           <= key;
         k2           <= k1;
         k3           <= k2;
         ctrl_q       <= bus.ctrl;
         hit_pulse    <= 1'b0;
         miss_pulse   <= 1'b0;
         escape_pulse <= 1'b0;
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  state     <= PLAY;
                  score     <= '0;
                  miss_cnt  <= '0;
                  lives     <= LIVES_RST;
                  whacked   <= '0;
                  playing   <= 1'b1;
                  game_over <= 1'b0;
               end
            end
            PLAY: begin
               score        <= score_next;
               miss_cnt     <= miss_next;
               lives        <= lives_next;
               // A lowered mole always starts its next appearance un-whacked.
               whacked      <= (whacked | hit) & bus.ctrl;
               hit_pulse    <= |hit;
               miss_pulse   <= |miss;
               escape_pulse <= |escape;
               if (lives_next == 3'd0) begin
                  state     <= OVER;
                  playing   <= 1'b0;
                  game_over <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               playing   <= 1'b0;
               game_over <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mole_hit_scorer.sv
// tb/tb_mole_hit_scorer.sv - self-checking bench for mole_hit_scorer
// Scripted vector table, randomized play against a game-level model, and corner sequences.
module tb_mole_hit_scorer;

   logic       CLOCK_50;
   logic       reset;
   logic       start;
   logic [7:0] key;
   logic [9:0] score;
   logic [7:0] miss_cnt;
   logic [2:0] lives;
   logic       hit_pulse, miss_pulse, escape_pulse, playing, game_over;

   mole_hit_scorer_if bus();

   mole_hit_scorer #(.SCORE_W(10), .MISS_W(8), .LIVES_INIT(5)) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .start        (start),
      .key          (key),
      .bus          (bus),
      .score        (score),
      .miss_cnt     (miss_cnt),
      .lives        (lives),
      .hit_pulse    (hit_pulse),
      .miss_pulse   (miss_pulse),
      .escape_pulse (escape_pulse),
      .playing      (playing),
      .game_over    (game_over)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   int n_tests = 0;
   int n_fail  = 0;

   // Game-level reference: a key press counts on the third edge after it is first seen.
   int       m_phase;   // 0 idle, 1 play, 2 over
   int       m_score, m_miss, m_lives;
   bit [7:0] m_wh;
   bit [7:0] m_keys [3];
   bit [7:0] m_cprev;
   bit       m_hp, m_mp, m_ep;

   task automatic model_reset();
      m_phase = 0; m_score = 0; m_miss = 0; m_lives = 5;
      m_wh = '0; m_cprev = '0; m_hp = 0; m_mp = 0; m_ep = 0;
      for (int i = 0; i < 3; i++) m_keys[i] = '0;
   endtask

   task automatic model_step(input bit st, input bit [7:0] c, input bit [7:0] k);
      bit [7:0] press, gone, wh_old;
      int hits, misses, escs;
      press = m_keys[1] & ~m_keys[2];
      gone  = m_cprev & ~c;
      wh_old = m_wh;
      hits = 0; misses = 0; escs = 0;
      m_hp = 0; m_mp = 0; m_ep = 0;
      if (m_phase == 1) begin
         for (int i = 0; i < 8; i++) begin
            if (press[i]) begin
               if (!c[i]) misses++;
               else if (!m_wh[i]) begin hits++; m_wh[i] = 1; end
            end
            if (gone[i] && !wh_old[i]) escs++;
            if (!c[i]) m_wh[i] = 0;
         end
         m_score = (m_score + hits > 1023) ? 1023 : m_score + hits;
         m_miss  = (m_miss + misses > 255) ? 255 : m_miss + misses;
         m_lives = (escs >= m_lives) ? 0 : m_lives - escs;
         m_hp = (hits > 0); m_mp = (misses > 0); m_ep = (escs > 0);
         if (m_lives == 0) m_phase = 2;
      end else if (st) begin
         m_phase = 1; m_score = 0; m_miss = 0; m_lives = 5; m_wh = '0;
      end
      m_keys[2] = m_keys[1]; m_keys[1] = m_keys[0]; m_keys[0] = k;
      m_cprev = c;
   endtask

   task automatic check_model(input string tag);
      n_tests++;
      if (score !== 10'(m_score) || miss_cnt !== 8'(m_miss) || lives !== 3'(m_lives) ||
          hit_pulse !== m_hp || miss_pulse !== m_mp || escape_pulse !== m_ep ||
          playing !== (m_phase == 1) || game_over !== (m_phase == 2) ||
          bus.visible !== (bus.ctrl & ~m_wh)) begin
         n_fail++;
         $display("FAIL model %s t=%0t got sc=%0d mi=%0d lv=%0d p=%b%b%b pg=%b%b vis=%h exp sc=%0d mi=%0d lv=%0d p=%b%b%b ph=%0d vis=%h",
                  tag, $time, score, miss_cnt, lives, hit_pulse, miss_pulse, escape_pulse,
                  playing, game_over, bus.visible, m_score, m_miss, m_lives, m_hp, m_mp, m_ep,
                  m_phase, bus.ctrl & ~m_wh);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge CLOCK_50);
      if (!reset) model_step(start, bus.ctrl, key);
      @(negedge CLOCK_50);
      if (!reset) check_model(tag);
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   typedef struct {
      bit       st;
      bit [7:0] c, k;
      int       sc, mi, lv;
      bit [2:0] pulses;   // hit, miss, escape
      bit [1:0] pg;       // playing, game_over
      bit [7:0] vis;
   } vec_t;

   function automatic vec_t mk(bit st, bit [7:0] c, bit [7:0] k, int sc, int mi, int lv,
                               bit [2:0] pulses, bit [1:0] pg, bit [7:0] vis);
      vec_t v;
      v.st = st; v.c = c; v.k = k; v.sc = sc; v.mi = mi; v.lv = lv;
      v.pulses = pulses; v.pg = pg; v.vis = vis;
      return v;
   endfunction

   vec_t tv [32];

   initial begin
      int hold;
      tv[0]  = mk(1'b1, 8'h04, 8'h00, 0, 0, 5, 3'b000, 2'b10, 8'h04);
      tv[1]  = mk(1'b0, 8'h04, 8'h04, 0, 0, 5, 3'b000, 2'b10, 8'h04);
      tv[2]  = mk(1'b0, 8'h04, 8'h04, 0, 0, 5, 3'b000, 2'b10, 8'h04);
      tv[3]  = mk(1'b0, 8'h04, 8'h04, 1, 0, 5, 3'b100, 2'b10, 8'h00);
      tv[4]  = mk(1'b0, 8'h04, 8'h04, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[5]  = mk(1'b0, 8'h04, 8'h00, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[6]  = mk(1'b0, 8'h04, 8'h00, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[7]  = mk(1'b0, 8'h04, 8'h00, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[8]  = mk(1'b0, 8'h04, 8'h04, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[9]  = mk(1'b0, 8'h04, 8'h04, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[10] = mk(1'b0, 8'h04, 8'h04, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[11] = mk(1'b0, 8'h04, 8'h20, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[12] = mk(1'b0, 8'h04, 8'h20, 1, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[13] = mk(1'b0, 8'h04, 8'h20, 1, 1, 5, 3'b010, 2'b10, 8'h00);
      tv[14] = mk(1'b0, 8'h81, 8'h00, 1, 1, 5, 3'b000, 2'b10, 8'h81);
      tv[15] = mk(1'b0, 8'h81, 8'h00, 1, 1, 5, 3'b000, 2'b10, 8'h81);
      tv[16] = mk(1'b0, 8'h00, 8'h00, 1, 1, 3, 3'b001, 2'b10, 8'h00);
      tv[17] = mk(1'b0, 8'h03, 8'h03, 1, 1, 3, 3'b000, 2'b10, 8'h03);
      tv[18] = mk(1'b0, 8'h03, 8'h03, 1, 1, 3, 3'b000, 2'b10, 8'h03);
      tv[19] = mk(1'b0, 8'h03, 8'h03, 3, 1, 3, 3'b100, 2'b10, 8'h00);
      tv[20] = mk(1'b0, 8'h00, 8'h00, 3, 1, 3, 3'b000, 2'b10, 8'h00);
      tv[21] = mk(1'b0, 8'h01, 8'h00, 3, 1, 3, 3'b000, 2'b10, 8'h01);
      tv[22] = mk(1'b0, 8'h00, 8'h00, 3, 1, 2, 3'b001, 2'b10, 8'h00);
      tv[23] = mk(1'b0, 8'h01, 8'h00, 3, 1, 2, 3'b000, 2'b10, 8'h01);
      tv[24] = mk(1'b0, 8'h00, 8'h00, 3, 1, 1, 3'b001, 2'b10, 8'h00);
      tv[25] = mk(1'b0, 8'h01, 8'h00, 3, 1, 1, 3'b000, 2'b10, 8'h01);
      tv[26] = mk(1'b0, 8'h00, 8'h00, 3, 1, 0, 3'b001, 2'b01, 8'h00);
      tv[27] = mk(1'b0, 8'h01, 8'h01, 3, 1, 0, 3'b000, 2'b01, 8'h01);
      tv[28] = mk(1'b0, 8'h01, 8'h01, 3, 1, 0, 3'b000, 2'b01, 8'h01);
      tv[29] = mk(1'b0, 8'h01, 8'h01, 3, 1, 0, 3'b000, 2'b01, 8'h01);
      tv[30] = mk(1'b1, 8'h00, 8'h00, 0, 0, 5, 3'b000, 2'b10, 8'h00);
      tv[31] = mk(1'b1, 8'h00, 8'h00, 0, 0, 5, 3'b000, 2'b10, 8'h00);

      // Reset state; visible follows ctrl even while reset is held.
      reset = 1'b1; start = 1'b0; key = '0; bus.ctrl = 8'h5A;
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      check_val("rst_score", int'(score), 0);
      check_val("rst_lives", int'(lives), 5);
      check_val("rst_flags", int'({playing, game_over, hit_pulse, miss_pulse, escape_pulse}), 0);
      check_val("rst_visible", int'(bus.visible), 'h5A);
      bus.ctrl = 8'h00;
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (3) tick("idle");

      for (int i = 0; i < 32; i++) begin
         start = tv[i].st; bus.ctrl = tv[i].c; key = tv[i].k;
         tick("table");
         n_tests++;
         if (int'(score) != tv[i].sc || int'(miss_cnt) != tv[i].mi || int'(lives) != tv[i].lv ||
             {hit_pulse, miss_pulse, escape_pulse} != tv[i].pulses ||
             {playing, game_over} != tv[i].pg || bus.visible != tv[i].vis) begin
            n_fail++;
            $display("FAIL vec%0d got sc=%0d mi=%0d lv=%0d p=%b pg=%b vis=%h exp sc=%0d mi=%0d lv=%0d p=%b pg=%b vis=%h",
                     i, score, miss_cnt, lives, {hit_pulse, miss_pulse, escape_pulse},
                     {playing, game_over}, bus.visible, tv[i].sc, tv[i].mi, tv[i].lv,
                     tv[i].pulses, tv[i].pg, tv[i].vis);
         end
      end
      start = 1'b0;

      // Randomized play with occasional restarts.
      hold = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (hold == 0) begin
            bus.ctrl = 8'($urandom);
            hold = $urandom_range(1, 6);
         end
         hold--;
         if ($urandom_range(0, 3) == 0) key = 8'($urandom & $urandom);
         start = ($urandom_range(0, 31) == 0);
         tick("random");
      end

      // Reset in mid-play, right as a hit pulse is showing.
      start = 1'b0; bus.ctrl = 8'h00; key = 8'h00;
      repeat (3) tick("pre");
      start = 1'b1; tick("restart");
      start = 1'b0; bus.ctrl = 8'h0F; key = 8'h0F;
      repeat (3) tick("pre_rst_hits");
      check_val("pre_rst_hit_pulse", int'(hit_pulse), 1);
      reset = 1'b1;
      model_reset();
      #1;
      check_val("midrst_score", int'(score), 0);
      check_val("midrst_flags", int'({playing, game_over, hit_pulse, miss_pulse, escape_pulse}), 0);
      @(negedge CLOCK_50);
      check_val("midrst_lives", int'(lives), 5);
      check_val("midrst_playing", int'(playing), 0);
      key = 8'h00; bus.ctrl = 8'h00;
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (2) tick("post_rst");

      // Score saturation: eight simultaneous hits per appearance.
      start = 1'b1; tick("sat_start");
      start = 1'b0;
      for (int r = 0; r < 129; r++) begin
         bus.ctrl = 8'hFF; key = 8'hFF;
         repeat (4) tick("sat_up");
         bus.ctrl = 8'h00; key = 8'h00;
         repeat (3) tick("sat_down");
         if (r == 127) check_val("score_at_max", int'(score), 1023);
      end
      check_val("score_saturated", int'(score), 1023);
      check_val("sat_lives", int'(lives), 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
